apb4_master_bridge: RTL and testbench
=====================================

# apb4_master_bridge

APB4 requester that turns a simple valid/ready request/response interface into APB4 master transactions. It drives the setup and access phases, honours slave wait states, returns read data and error status, and aborts hung transfers with a timeout. It sits between a core-side load/store port and APB4 slave peripherals such as the clock/reset control unit.

## Interface
- ADDR_WIDTH, 32, width of req_addr_i / paddr_o
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- TIMEOUT_WIDTH, 8, width of the wait-state counter
- TIMEOUT, 255, maximum ACCESS cycles with pready low before abort; 0 disables the timeout
- clk_i  in  1  single clock; also drives APB4 pclk-domain logic
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_WIDTH  byte address, passed unchanged to paddr_o
- req_wdata_i  in  DATA_WIDTH  write data
- req_strb_i  in  DATA_WIDTH/8  write strobes; forced to 0 on reads
- req_prot_i  in  3  APB4 pprot
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_err_o  out  1  pslverr or timeout
- rsp_timeout_o  out  1  transfer aborted by timeout
- paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o  out  APB4 master outputs
- pready_i, prdata_i, pslverr_i  in  APB4 slave returns

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready_o=1. On req_valid_i, latch write/addr/wdata/strb/prot and go to SETUP.
- SETUP: psel_o=1, penable_o=0. Go unconditionally to ACCESS.
- ACCESS: psel_o=1, penable_o=1. On pready_i=1, capture prdata_i (reads only) and pslverr_i, then go to RESP.
- ACCESS wait: each cycle with pready_i=0 increments the counter. With TIMEOUT≠0 and the counter equal to TIMEOUT-1, the next pready_i=0 cycle ends the transfer: go to RESP with rsp_err_o=1, rsp_timeout_o=1, rdata=0.
- RESP: rsp_valid_o=1 and all response fields stable. On rsp_ready_i, go to IDLE.
- req_ready_o is 1 only in IDLE. There is no request pipelining: one transfer is outstanding at a time.
- APB outputs paddr/pwrite/pwdata/pstrb/pprot hold the latched values from SETUP through the end of ACCESS. Outside SETUP/ACCESS, psel_o=penable_o=0 and the other APB outputs hold their last values.
- The counter clears on entry to SETUP. It saturates and never wraps.
- pslverr_i and prdata_i are sampled only when psel&penable&pready are all 1.

## Timing
- Reset (rst_i high, any state): state=IDLE, psel_o=penable_o=0, pwrite_o=0, paddr/pwdata/pstrb/pprot=0, rsp_valid_o=0, rsp_err_o=0, rsp_timeout_o=0, rsp_rdata_o=0, counter=0, req_ready_o=1.
- Reset asserted mid-ACCESS drops psel_o/penable_o asynchronously. No response is generated.
- Zero-wait transfer: request accepted at cycle 0, SETUP at cycle 1, ACCESS at cycle 2 with pready sampled, rsp_valid_o at cycle 3.
- With N wait states, rsp_valid_o rises at cycle 3+N.
- Minimum request-to-request spacing is 4 cycles: the next acceptance is in the cycle after the response handshake.
- Timeout with TIMEOUT=T: ACCESS lasts exactly T+1 cycles, and rsp_valid_o rises at cycle 3+T.
- All outputs are registered or decoded from state only. There is no combinational path from pready_i/prdata_i to any output.

## Test plan
- Write, addr 0x0000_0000, data 0x0000_0003, strb 0xF, pready tied 1 -> psel high cycles 1–2, penable high cycle 2 only, pwdata=0x3; rsp_valid cycle 3, err=0, rdata=0.
- Read, addr 0x4, slave inserts 3 wait states, then returns prdata=0xA5A5_0001 -> ACCESS lasts 4 cycles; rsp_rdata=0xA5A5_0001 at cycle 6; pstrb=0 throughout.
- Write with pslverr=1 on the completing cycle -> rsp_err=1, rsp_timeout=0; next request accepted normally.
- TIMEOUT=4, pready held 0 -> ACCESS lasts 5 cycles, psel drops, rsp_valid at cycle 7 with err=1, timeout=1, rdata=0.
- rsp_ready held 0 for 5 cycles, then two back-to-back requests presented -> second request not accepted until the cycle after the first response handshake; no APB activity while in RESP.
- rst_i pulsed during ACCESS of a read -> psel/penable go 0 immediately, no rsp_valid; after release, a fresh read completes correctly.

Source files
------------

// File: rtl/apb4_master_bridge.sv
// ---------------------------------------------------------------------------
// apb4_master_bridge
//
// Purpose:
//   Turns a simple valid/ready request/response port (as seen from a core's
//   load/store unit) into APB4 master transactions. Exactly one transfer is
//   in flight at a time. The bridge walks the APB setup and access phases,
//   waits for the slave's pready, hands back read data and error status, and
//   aborts a transfer whose slave never answers.
//
// Parameters:
//   ADDR_WIDTH     width of req_addr_i / paddr_o
//   DATA_WIDTH     data width; strobe width is DATA_WIDTH/8
//   TIMEOUT_WIDTH  width of the wait-state counter
//   TIMEOUT        wait cycles tolerated in ACCESS before abort (0 = never)
//
// Ports:
//   clk_i, rst_i          clock and asynchronous active-high reset
//   req_valid_i/ready_o   request handshake (ready only while idle)
//   req_write_i           1 = write, 0 = read
//   req_addr_i            byte address, forwarded unchanged to paddr_o
//   req_wdata_i           write data
//   req_strb_i            write strobes (driven as zero for reads)
//   req_prot_i            APB4 protection attributes
//   rsp_valid_o/ready_i   response handshake
//   rsp_rdata_o           read data (zero for writes and timeouts)
//   rsp_err_o             slave error or timeout
//   rsp_timeout_o         transfer was aborted by the timeout
//   paddr_o .. pstrb_o    APB4 master outputs
//   pready_i, prdata_i,
//   pslverr_i             APB4 slave returns
// ---------------------------------------------------------------------------
module apb4_master_bridge #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT_WIDTH = 8,
  parameter int TIMEOUT       = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,

  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,

  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                    pready_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pslverr_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Abort threshold expressed in the counter's own width. The counter holds
  // the number of pready-low ACCESS cycles seen so far; a further pready-low
  // cycle while it already equals TIMEOUT ends the transfer, so ACCESS lasts
  // TIMEOUT+1 cycles in total when the slave never answers.
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CNT = TIMEOUT_WIDTH'(TIMEOUT);
  localparam bit                       TIMEOUT_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                  state_q;
  logic [TIMEOUT_WIDTH-1:0] waitCnt_q;
  logic [TIMEOUT_WIDTH-1:0] waitCnt_d;
  logic                    timeoutHit;

  logic                    reqReady_q;
  logic                    rspValid_q;
  logic [DATA_WIDTH-1:0]   rspRdata_q;
  logic                    rspErr_q;
  logic                    rspTimeout_q;

  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [2:0]              pprot_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [STRB_WIDTH-1:0]   pstrb_q;

  // Saturating increment of the wait-state counter: once it reaches all-ones
  // it stays there instead of wrapping back to zero, so a large TIMEOUT close
  // to the counter's range can never be skipped over.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (waitCnt_q != {TIMEOUT_WIDTH{1'b1}}) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end
  end

  // Timeout decision for the current ACCESS cycle. It only matters when the
  // slave is still holding pready low; a late pready always wins.
  assign timeoutHit = TIMEOUT_EN && (waitCnt_q == TIMEOUT_CNT);

  // Main transfer FSM. Every output is a register updated here, so nothing
  // the slave drives (pready/prdata/pslverr) reaches an output in the same
  // cycle. The APB address/data/control registers double as the request
  // latch: they load on acceptance and otherwise keep their last value, which
  // gives stable APB signals through SETUP and ACCESS and a quiet bus after.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      waitCnt_q    <= '0;
      reqReady_q   <= 1'b1;
      rspValid_q   <= 1'b0;
      rspRdata_q   <= '0;
      rspErr_q     <= 1'b0;
      rspTimeout_q <= 1'b0;
      paddr_q      <= '0;
      pprot_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            paddr_q    <= req_addr_i;
            pprot_q    <= req_prot_i;
            pwrite_q   <= req_write_i;
            pwdata_q   <= req_wdata_i;
            // Reads must present all-zero strobes on the bus.
            pstrb_q    <= req_write_i ? req_strb_i : '0;
            psel_q     <= 1'b1;
            penable_q  <= 1'b0;
            reqReady_q <= 1'b0;
            waitCnt_q  <= '0;
            state_q    <= SETUP;
          end
        end

        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end

        ACCESS: begin
          if (pready_i) begin
            // Slave completed: sample its data (reads only) and error flag.
            rspRdata_q   <= pwrite_q ? '0 : prdata_i;
            rspErr_q     <= pslverr_i;
            rspTimeout_q <= 1'b0;
            rspValid_q   <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            state_q      <= RESP;
          end else if (timeoutHit) begin
            // Slave hung: abandon the transfer and report it as an error.
            rspRdata_q   <= '0;
            rspErr_q     <= 1'b1;
            rspTimeout_q <= 1'b1;
            rspValid_q   <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            state_q      <= RESP;
          end else begin
            waitCnt_q <= waitCnt_d;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            rspValid_q <= 1'b0;
            reqReady_q <= 1'b1;
            state_q    <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Drive the ports straight from the registers above.
  assign req_ready_o   = reqReady_q;
  assign rsp_valid_o   = rspValid_q;
  assign rsp_rdata_o   = rspRdata_q;
  assign rsp_err_o     = rspErr_q;
  assign rsp_timeout_o = rspTimeout_q;

  assign paddr_o   = paddr_q;
  assign pprot_o   = pprot_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign pwdata_o  = pwdata_q;
  assign pstrb_o   = pstrb_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb4_master_bridge
//
// Self-checking bench for apb4_master_bridge (built with TIMEOUT = 4 so the
// abort path is reachable quickly). Requests come from a table of vectors;
// each accepted request pushes its expected response onto a scoreboard queue
// that is popped when the response handshake happens. A small APB slave
// model answers after a programmable number of wait states or never.
// ---------------------------------------------------------------------------
module tb_apb4_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TMO = 4;

  logic          clk_i;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [SW-1:0] req_strb_i;
  logic [2:0]    req_prot_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;
  logic [AW-1:0] paddr_o;
  logic [2:0]    pprot_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [DW-1:0] pwdata_o;
  logic [SW-1:0] pstrb_o;
  logic          pready_i;
  logic [DW-1:0] prdata_i;
  logic          pslverr_i;

  apb4_master_bridge #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .TIMEOUT_WIDTH(8),
    .TIMEOUT      (TMO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_strb_i   (req_strb_i),
    .req_prot_i   (req_prot_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .paddr_o      (paddr_o),
    .pprot_o      (pprot_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .pwdata_o     (pwdata_o),
    .pstrb_o      (pstrb_o),
    .pready_i     (pready_i),
    .prdata_i     (prdata_i),
    .pslverr_i    (pslverr_i)
  );

  // One request plus the slave behaviour it meets and what must come back.
  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int            waits;
    logic [DW-1:0] prdata;
    logic          slverr;
    logic          hang;
    logic [DW-1:0] expRdata;
    logic          expErr;
    logic          expTmo;
    int            expLat;
    int            expPsel;
    int            expPen;
  } vec_t;

  // Scoreboard entry: expected response plus timing of the transfer.
  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
    int            lat;
    int            psel;
    int            pen;
    int            accCycle;
  } exp_t;

  exp_t sbQ[$];
  exp_t stExp;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  int pselCnt = 0;
  int penCnt = 0;
  int riseCycle = 0;
  int lastAccCycle = 0;
  int lastHsCycle = 0;
  int accCount = 0;
  logic prevRspValid = 1'b0;

  logic [AW-1:0] stAddr, curAddr;
  logic          stWrite, curWrite;
  logic [DW-1:0] stWdata, curWdata;
  logic [SW-1:0] stPstrb, curPstrb;
  logic [2:0]    stProt, curProt;
  int            stSlvWaits, slvWaits;
  logic [DW-1:0] stSlvData, slvData;
  logic          stSlvErr, slvErr;
  logic          stSlvHang, slvHang;
  int            accessCnt = 0;

  vec_t vecs[9];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic reportFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: got no completion, expected completion (cycle %0d)", name, cyc);
  endtask

  function automatic vec_t mkVec(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic [SW-1:0] s, input logic [2:0] p, input int waits,
                                 input logic [DW-1:0] rd, input logic se, input logic hang,
                                 input logic [DW-1:0] eRd, input logic eErr, input logic eTmo,
                                 input int eLat, input int ePsel, input int ePen);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = d; v.strb = s; v.prot = p;
    v.waits = waits; v.prdata = rd; v.slverr = se; v.hang = hang;
    v.expRdata = eRd; v.expErr = eErr; v.expTmo = eTmo;
    v.expLat = eLat; v.expPsel = ePsel; v.expPen = ePen;
    return v;
  endfunction

  // Drive a request onto the port and stage its expectations; they become
  // current when the bench sees the handshake.
  task automatic presentRequest(input vec_t v);
    req_write_i = v.write;
    req_addr_i  = v.addr;
    req_wdata_i = v.wdata;
    req_strb_i  = v.strb;
    req_prot_i  = v.prot;
    req_valid_i = 1'b1;
    stAddr  = v.addr;
    stWrite = v.write;
    stWdata = v.wdata;
    stPstrb = v.write ? v.strb : '0;
    stProt  = v.prot;
    stSlvWaits = v.waits;
    stSlvData  = v.prdata;
    stSlvErr   = v.slverr;
    stSlvHang  = v.hang;
    stExp.rdata = v.expRdata;
    stExp.err   = v.expErr;
    stExp.tmo   = v.expTmo;
    stExp.lat   = v.expLat;
    stExp.psel  = v.expPsel;
    stExp.pen   = v.expPen;
    stExp.accCycle = 0;
  endtask

  // Advance one clock. Handshakes are judged just before the rising edge
  // from the values sitting on the port; after the falling edge the slave
  // model updates its inputs and the monitor checks the DUT outputs.
  task automatic step();
    bit accepted;
    exp_t e;
    accepted = 1'b0;
    if (req_valid_i && req_ready_o) begin
      e = stExp;
      e.accCycle = cyc;
      sbQ.push_back(e);
      curAddr = stAddr; curWrite = stWrite; curWdata = stWdata;
      curPstrb = stPstrb; curProt = stProt;
      slvWaits = stSlvWaits; slvData = stSlvData; slvErr = stSlvErr; slvHang = stSlvHang;
      lastAccCycle = cyc;
      accCount++;
      accepted = 1'b1;
    end
    if (rsp_valid_o && rsp_ready_i) begin
      if (sbQ.size() == 0) begin
        reportFail("rsp_handshake_unexpected");
      end else begin
        e = sbQ.pop_front();
        checkOutput("rsp_latency", 64'(riseCycle - e.accCycle), 64'(e.lat));
        checkOutput("psel_cycles", 64'(pselCnt), 64'(e.psel));
        checkOutput("penable_cycles", 64'(penCnt), 64'(e.pen));
      end
      pselCnt = 0;
      penCnt = 0;
      lastHsCycle = cyc;
    end

    @(negedge clk_i);
    cyc++;
    if (accepted) req_valid_i = 1'b0;

    if (psel_o && penable_o) begin
      if (!slvHang && accessCnt == slvWaits) begin
        pready_i  = 1'b1;
        prdata_i  = slvData;
        pslverr_i = slvErr;
      end else begin
        pready_i  = 1'b0;
        prdata_i  = ~slvData;
        pslverr_i = 1'b1;
      end
      accessCnt++;
    end else begin
      pready_i  = 1'b0;
      prdata_i  = 32'h5A5A_5A5A;
      pslverr_i = 1'b0;
      accessCnt = 0;
    end

    if (rsp_valid_o && !prevRspValid) riseCycle = cyc;
    prevRspValid = rsp_valid_o;
    if (psel_o) begin
      pselCnt++;
      checkOutput("paddr", 64'(paddr_o), 64'(curAddr));
      checkOutput("pwrite", 64'(pwrite_o), 64'(curWrite));
      checkOutput("pwdata", 64'(pwdata_o), 64'(curWdata));
      checkOutput("pstrb", 64'(pstrb_o), 64'(curPstrb));
      checkOutput("pprot", 64'(pprot_o), 64'(curProt));
      checkOutput("req_ready_busy", 64'(req_ready_o), 64'd0);
    end
    if (penable_o) begin
      penCnt++;
      checkOutput("penable_with_psel", 64'(psel_o), 64'd1);
    end
    if (rsp_valid_o) begin
      checkOutput("apb_quiet_in_resp", 64'(psel_o), 64'd0);
      checkOutput("req_ready_in_resp", 64'(req_ready_o), 64'd0);
      if (sbQ.size() == 0) begin
        reportFail("rsp_valid_unexpected");
      end else begin
        checkOutput("rsp_rdata", 64'(rsp_rdata_o), 64'(sbQ[0].rdata));
        checkOutput("rsp_err", 64'(rsp_err_o), 64'(sbQ[0].err));
        checkOutput("rsp_timeout", 64'(rsp_timeout_o), 64'(sbQ[0].tmo));
      end
    end
    if (!psel_o && !rsp_valid_o) checkOutput("req_ready_idle", 64'(req_ready_o), 64'd1);
  endtask

  // Step until the pending request is taken and every response returned.
  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((req_valid_i || sbQ.size() != 0) && n < limit) begin
      step();
      n++;
    end
    if (req_valid_i || sbQ.size() != 0) reportFail("drain_budget");
  endtask

  task automatic applyStimulus(input vec_t v);
    int n;
    n = 0;
    while (!req_ready_o && n < 50) begin
      step();
      n++;
    end
    presentRequest(v);
    drain(60);
  endtask

  initial begin
    int n;
    int holdCnt;
    int accBefore;

    rst_i = 1'b1;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    req_strb_i = '0; req_prot_i = '0; rsp_ready_i = 1'b1;
    pready_i = 1'b0; prdata_i = '0; pslverr_i = 1'b0;
    slvWaits = 0; slvData = '0; slvErr = 1'b0; slvHang = 1'b0;
    curAddr = '0; curWrite = 1'b0; curWdata = '0; curPstrb = '0; curProt = '0;

    vecs[0] = mkVec(1'b1, 32'h0000_0000, 32'h0000_0003, 4'hF, 3'd0, 0, 32'h7777_0000, 1'b0, 1'b0,
                    32'h0, 1'b0, 1'b0, 3, 2, 1);
    vecs[1] = mkVec(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 3'd0, 3, 32'hA5A5_0001, 1'b0, 1'b0,
                    32'hA5A5_0001, 1'b0, 1'b0, 6, 5, 4);
    vecs[2] = mkVec(1'b1, 32'h0000_0010, 32'h1234_5678, 4'h5, 3'd1, 1, 32'h0000_9999, 1'b1, 1'b0,
                    32'h0, 1'b1, 1'b0, 4, 3, 2);
    vecs[3] = mkVec(1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 3'd2, 0, 32'hCAFE_F00D, 1'b0, 1'b0,
                    32'hCAFE_F00D, 1'b0, 1'b0, 3, 2, 1);
    vecs[4] = mkVec(1'b0, 32'h0000_0024, 32'h0000_0000, 4'h0, 3'd0, 0, 32'h0000_1357, 1'b0, 1'b1,
                    32'h0, 1'b1, 1'b1, 7, 6, 5);
    vecs[5] = mkVec(1'b1, 32'h0000_0028, 32'hDEAD_0001, 4'h3, 3'd0, 0, 32'h0000_2468, 1'b0, 1'b1,
                    32'h0, 1'b1, 1'b1, 7, 6, 5);
    vecs[6] = mkVec(1'b0, 32'h0000_002C, 32'h0000_0000, 4'h0, 3'd0, 4, 32'h0F0F_0F0F, 1'b0, 1'b0,
                    32'h0F0F_0F0F, 1'b0, 1'b0, 7, 6, 5);
    vecs[7] = mkVec(1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 3'd7, 2, 32'h8000_0001, 1'b1, 1'b0,
                    32'h8000_0001, 1'b1, 1'b0, 5, 4, 3);
    vecs[8] = mkVec(1'b1, 32'h0000_0030, 32'h0000_00AB, 4'hC, 3'd2, 3, 32'h0000_1111, 1'b0, 1'b0,
                    32'h0, 1'b0, 1'b0, 6, 5, 4);

    // Reset values while reset is held.
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_psel", 64'(psel_o), 64'd0);
    checkOutput("rst_penable", 64'(penable_o), 64'd0);
    checkOutput("rst_pwrite", 64'(pwrite_o), 64'd0);
    checkOutput("rst_paddr", 64'(paddr_o), 64'd0);
    checkOutput("rst_pwdata", 64'(pwdata_o), 64'd0);
    checkOutput("rst_pstrb", 64'(pstrb_o), 64'd0);
    checkOutput("rst_pprot", 64'(pprot_o), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    checkOutput("rst_rsp_err", 64'(rsp_err_o), 64'd0);
    checkOutput("rst_rsp_timeout", 64'(rsp_timeout_o), 64'd0);
    checkOutput("rst_rsp_rdata", 64'(rsp_rdata_o), 64'd0);
    checkOutput("rst_req_ready", 64'(req_ready_o), 64'd1);
    rst_i = 1'b0;
    step();

    // Table of single transfers with the response consumed immediately.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
    end

    // Response held for several cycles with a second request already waiting.
    rsp_ready_i = 1'b0;
    n = 0;
    while (!req_ready_o && n < 20) begin
      step();
      n++;
    end
    presentRequest(mkVec(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'd0, 0, 32'h1111_2222, 1'b0, 1'b0,
                         32'h1111_2222, 1'b0, 1'b0, 3, 2, 1));
    step();
    presentRequest(mkVec(1'b1, 32'h0000_0044, 32'h0000_0055, 4'hF, 3'd0, 0, 32'h3333_4444, 1'b0, 1'b0,
                         32'h0, 1'b0, 1'b0, 3, 2, 1));
    accBefore = accCount;
    holdCnt = 0;
    n = 0;
    while (holdCnt < 6 && n < 40) begin
      step();
      n++;
      if (rsp_valid_o) holdCnt++;
    end
    checkOutput("hold_no_second_accept", 64'(accCount - accBefore), 64'd0);
    rsp_ready_i = 1'b1;
    n = 0;
    while (accCount == accBefore && n < 20) begin
      step();
      n++;
    end
    if (accCount == accBefore) reportFail("b2b_second_accept");
    else checkOutput("b2b_spacing", 64'(lastAccCycle - lastHsCycle), 64'd1);
    drain(40);

    // Reset pulsed in the middle of a read's ACCESS phase.
    presentRequest(mkVec(1'b0, 32'h0000_0080, 32'h0, 4'h0, 3'd0, 3, 32'h7654_3210, 1'b0, 1'b0,
                         32'h7654_3210, 1'b0, 1'b0, 6, 5, 4));
    n = 0;
    while (!(psel_o && penable_o) && n < 20) begin
      step();
      n++;
    end
    checkOutput("reached_access", 64'(penable_o), 64'd1);
    #1 rst_i = 1'b1;
    #1;
    checkOutput("rst_async_psel", 64'(psel_o), 64'd0);
    checkOutput("rst_async_penable", 64'(penable_o), 64'd0);
    sbQ.delete();
    pselCnt = 0;
    penCnt = 0;
    step();
    step();
    rst_i = 1'b0;
    checkOutput("post_rst_req_ready", 64'(req_ready_o), 64'd1);
    checkOutput("post_rst_paddr", 64'(paddr_o), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("post_rst_no_rsp", 64'(rsp_valid_o), 64'd0);
    end
    applyStimulus(mkVec(1'b0, 32'h0000_0084, 32'h0, 4'h0, 3'd1, 1, 32'h0BAD_F00D, 1'b0, 1'b0,
                        32'h0BAD_F00D, 1'b0, 1'b0, 4, 3, 2));

    step();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
